// File: rtl/axi_pipeline_add_cmp_pkg.sv
// Shared definitions for the chunked {carry,result} vs threshold comparator:
// chunk count helper, compare-state encoding and the per-chunk compare step.
package axi_pipeline_add_cmp_pkg;

    // Widest slice the chunk-compare helper can take; slices are zero-extended to this.
    localparam int MAX_CHUNK_SZ = 64;

    typedef logic [1:0] cmp_state_t;

    localparam cmp_state_t CMP_EQ = 2'b00;
    localparam cmp_state_t CMP_GT = 2'b01;
    localparam cmp_state_t CMP_LT = 2'b10;

    function automatic int num_chunks(input int dwidth, input int chunk_sz);
        return dwidth / chunk_sz;
    endfunction

    // A differing slice decides the outcome; an equal slice keeps the verdict of the lower chunks.
    function automatic cmp_state_t chunk_compare(input logic [MAX_CHUNK_SZ-1:0] lhs,
                                                 input logic [MAX_CHUNK_SZ-1:0] rhs,
                                                 input cmp_state_t prev_state);
        if (lhs > rhs) begin
            return CMP_GT;
        end else if (lhs < rhs) begin
            return CMP_LT;
        end else begin
            return prev_state;
        end
    endfunction

endpackage

// File: rtl/axi_pipeline_add_cmp_stage.sv
// One pipeline stage: registers the beat's pass-through fields and its cmp copy,
// and folds chunk STAGE_IDX of result vs cmp into the running compare state.
// CHUNK_SZ must not exceed MAX_CHUNK_SZ from the package.
module axi_pipeline_cmp_stage
    import axi_pipeline_add_cmp_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int UWIDTH    = 1,
    parameter int CHUNK_SZ  = 16,
    parameter int STAGE_IDX = 0
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              advance,
    input  logic              prev_valid,
    input  logic [UWIDTH-1:0] prev_user,
    input  logic [DWIDTH-1:0] prev_a,
    input  logic [DWIDTH-1:0] prev_b,
    input  logic [DWIDTH-1:0] prev_result,
    input  logic              prev_carry,
    input  logic [DWIDTH-1:0] prev_cmp,
    input  cmp_state_t        prev_state,
    output logic              valid,
    output logic [UWIDTH-1:0] user,
    output logic [DWIDTH-1:0] a,
    output logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] result,
    output logic              carry,
    output logic [DWIDTH-1:0] cmp,
    output cmp_state_t        state
);

    localparam int LO = STAGE_IDX * CHUNK_SZ;

    logic [MAX_CHUNK_SZ-1:0] result_slice;
    logic [MAX_CHUNK_SZ-1:0] cmp_slice;

    assign result_slice = MAX_CHUNK_SZ'(prev_result[LO +: CHUNK_SZ]);
    assign cmp_slice    = MAX_CHUNK_SZ'(prev_cmp[LO +: CHUNK_SZ]);

    // Shift the whole beat (bubbles included) in on advance and update the compare state.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            valid  <= 1'b0;
            user   <= '0;
            a      <= '0;
            b      <= '0;
            result <= '0;
            carry  <= 1'b0;
            cmp    <= '0;
            state  <= CMP_EQ;
        end else if (advance) begin
            valid  <= prev_valid;
            user   <= prev_user;
            a      <= prev_a;
            b      <= prev_b;
            result <= prev_result;
            carry  <= prev_carry;
            cmp    <= prev_cmp;
            state  <= chunk_compare(result_slice, cmp_slice, prev_state);
        end
    end

endmodule

// File: rtl/axi_pipeline_add_cmp.sv
// Compares the adder's extended sum {carry,result} against a per-beat threshold,
// one CHUNK_SZ slice per stage from LSB to MSB, and emits ge/eq with the beat.
// DWIDTH must be a multiple of CHUNK_SZ.
module axi_pipeline_add_cmp
    import axi_pipeline_add_cmp_pkg::*;
#(
    parameter int DWIDTH   = 64,
    parameter int UWIDTH   = 1,
    parameter int CHUNK_SZ = 16
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [DWIDTH-1:0] cmp,
    output logic              s_axi_ready,
    input  logic              s_axi_valid,
    input  logic [DWIDTH-1:0] s_axi_data_a,
    input  logic [DWIDTH-1:0] s_axi_data_b,
    input  logic [DWIDTH-1:0] s_axi_data_result,
    input  logic              s_axi_data_carry,
    input  logic [UWIDTH-1:0] s_axi_user,
    input  logic              m_axi_ready,
    output logic              m_axi_valid,
    output logic [DWIDTH-1:0] m_axi_data_a,
    output logic [DWIDTH-1:0] m_axi_data_b,
    output logic [DWIDTH-1:0] m_axi_data_result,
    output logic              m_axi_data_carry,
    output logic [UWIDTH-1:0] m_axi_user,
    output logic              m_axi_ge,
    output logic              m_axi_eq
);

    localparam int NUM_CHUNKS = num_chunks(DWIDTH, CHUNK_SZ);

    // Index 0 is the upstream beat; index i (i >= 1) is the output of stage i-1.
    logic              stage_valid  [0:NUM_CHUNKS];
    logic [UWIDTH-1:0] stage_user   [0:NUM_CHUNKS];
    logic [DWIDTH-1:0] stage_a      [0:NUM_CHUNKS];
    logic [DWIDTH-1:0] stage_b      [0:NUM_CHUNKS];
    logic [DWIDTH-1:0] stage_result [0:NUM_CHUNKS];
    logic              stage_carry  [0:NUM_CHUNKS];
    logic [DWIDTH-1:0] stage_cmp    [0:NUM_CHUNKS];
    cmp_state_t        stage_state  [0:NUM_CHUNKS];

    logic advance;

    // The pipe only stalls when a finished beat is stuck at the output.
    assign advance     = m_axi_ready | ~stage_valid[NUM_CHUNKS];
    assign s_axi_ready = advance;

    assign stage_valid[0]  = s_axi_valid;
    assign stage_user[0]   = s_axi_user;
    assign stage_a[0]      = s_axi_data_a;
    assign stage_b[0]      = s_axi_data_b;
    assign stage_result[0] = s_axi_data_result;
    assign stage_carry[0]  = s_axi_data_carry;
    assign stage_cmp[0]    = cmp;
    assign stage_state[0]  = CMP_EQ;

    for (genvar i = 0; i < NUM_CHUNKS; i++) begin : g_stage
        axi_pipeline_cmp_stage #(
            .DWIDTH    (DWIDTH),
            .UWIDTH    (UWIDTH),
            .CHUNK_SZ  (CHUNK_SZ),
            .STAGE_IDX (i)
        ) u_stage (
            .clk         (clk),
            .areset      (areset),
            .advance     (advance),
            .prev_valid  (stage_valid[i]),
            .prev_user   (stage_user[i]),
            .prev_a      (stage_a[i]),
            .prev_b      (stage_b[i]),
            .prev_result (stage_result[i]),
            .prev_carry  (stage_carry[i]),
            .prev_cmp    (stage_cmp[i]),
            .prev_state  (stage_state[i]),
            .valid       (stage_valid[i+1]),
            .user        (stage_user[i+1]),
            .a           (stage_a[i+1]),
            .b           (stage_b[i+1]),
            .result      (stage_result[i+1]),
            .carry       (stage_carry[i+1]),
            .cmp         (stage_cmp[i+1]),
            .state       (stage_state[i+1])
        );
    end

    assign m_axi_valid       = stage_valid[NUM_CHUNKS];
    assign m_axi_user        = stage_user[NUM_CHUNKS];
    assign m_axi_data_a      = stage_a[NUM_CHUNKS];
    assign m_axi_data_b      = stage_b[NUM_CHUNKS];
    assign m_axi_data_result = stage_result[NUM_CHUNKS];
    assign m_axi_data_carry  = stage_carry[NUM_CHUNKS];

    // A set carry puts the sum above any DWIDTH-bit threshold; otherwise decode the final state.
    always_comb begin
        m_axi_ge = 1'b1;
        m_axi_eq = 1'b0;
        if (!stage_carry[NUM_CHUNKS]) begin
            m_axi_ge = (stage_state[NUM_CHUNKS] != CMP_LT);
            m_axi_eq = (stage_state[NUM_CHUNKS] == CMP_EQ);
        end
    end

endmodule
